// File: rtl/nios_mtl_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and
// compares them against the expected build, reporting flags and captured values.
module nios_mtl_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1460600513,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BOOT  = 3'd1;
    localparam logic [2:0] S_RD_ID = 3'd2;
    localparam logic [2:0] S_WT_ID = 3'd3;
    localparam logic [2:0] S_RD_TS = 3'd4;
    localparam logic [2:0] S_WT_TS = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_RST   = AUTO_START ? S_BOOT : S_IDLE;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_addr;
    logic             r_read;
    logic             r_busy;
    logic             r_done;
    logic             r_id_ok;
    logic             r_ts_ok;
    logic             r_timeout;
    logic [31:0]      r_id_value;
    logic [31:0]      r_ts_value;

    logic [2:0]       w_state;
    logic [CNT_W-1:0] w_cnt;
    logic             w_addr;
    logic             w_read;
    logic             w_busy;
    logic             w_done;
    logic             w_id_ok;
    logic             w_ts_ok;
    logic             w_timeout;
    logic [31:0]      w_id_value;
    logic [31:0]      w_ts_value;

    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_tmo_hit;

    // The abort fires on the edge that would make the count equal the limit.
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_tmo_hit = (TMO_LIMIT != '0) && (w_cnt_inc == TMO_LIMIT);

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_addr     = r_addr;
        w_read     = r_read;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_id_ok    = r_id_ok;
        w_ts_ok    = r_ts_ok;
        w_timeout  = r_timeout;
        w_id_value = r_id_value;
        w_ts_value = r_ts_value;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_id_ok    = 1'b0;
                    w_ts_ok    = 1'b0;
                    w_timeout  = 1'b0;
                    w_id_value = '0;
                    w_ts_value = '0;
                    w_state    = S_RD_ID;
                    w_read     = 1'b1;
                    w_addr     = 1'b0;
                    w_busy     = 1'b1;
                    w_cnt      = '0;
                end
            end
            S_BOOT: begin
                w_state = S_RD_ID;
                w_read  = 1'b1;
                w_addr  = 1'b0;
                w_busy  = 1'b1;
                w_cnt   = '0;
            end
            S_RD_ID, S_RD_TS: begin
                w_cnt = w_cnt_inc;
                if (w_tmo_hit) begin
                    w_state   = S_DONE;
                    w_timeout = 1'b1;
                    w_read    = 1'b0;
                    w_busy    = 1'b0;
                    w_done    = 1'b1;
                end else if (!avm_waitrequest) begin
                    w_state = (r_state == S_RD_ID) ? S_WT_ID : S_WT_TS;
                    w_read  = 1'b0;
                end
            end
            S_WT_ID: begin
                w_cnt = w_cnt_inc;
                if (avm_readdatavalid) begin
                    w_id_value = avm_readdata;
                    w_id_ok    = (avm_readdata == EXPECTED_ID);
                    w_state    = S_RD_TS;
                    w_read     = 1'b1;
                    w_addr     = 1'b1;
                    w_cnt      = '0;
                end else if (w_tmo_hit) begin
                    w_state   = S_DONE;
                    w_timeout = 1'b1;
                    w_busy    = 1'b0;
                    w_done    = 1'b1;
                end
            end
            S_WT_TS: begin
                w_cnt = w_cnt_inc;
                if (avm_readdatavalid) begin
                    w_ts_value = avm_readdata;
                    w_ts_ok    = (avm_readdata == EXPECTED_TIMESTAMP);
                    w_state    = S_DONE;
                    w_busy     = 1'b0;
                    w_done     = 1'b1;
                end else if (w_tmo_hit) begin
                    w_state   = S_DONE;
                    w_timeout = 1'b1;
                    w_busy    = 1'b0;
                    w_done    = 1'b1;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
                w_read  = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    // State and every output are registered together.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_RST;
            r_cnt      <= '0;
            r_addr     <= 1'b0;
            r_read     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_timeout  <= 1'b0;
            r_id_value <= '0;
            r_ts_value <= '0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_addr     <= w_addr;
            r_read     <= w_read;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_id_ok    <= w_id_ok;
            r_ts_ok    <= w_ts_ok;
            r_timeout  <= w_timeout;
            r_id_value <= w_id_value;
            r_ts_value <= w_ts_value;
        end
    end

    assign avm_address = r_addr;
    assign avm_read    = r_read;
    assign busy        = r_busy;
    assign done        = r_done;
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign timeout     = r_timeout;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

endmodule
